// File: rtl/sr_reg_bank.sv
// Multi-channel set/reset register bank: raw S/R inputs are synchronised,
// debounced and applied to Q with a selectable S&R conflict rule.
module sr_reg_bank #(
  parameter int unsigned         CHANNELS        = 4,
  parameter int unsigned         SYNC_STAGES     = 2,
  parameter int unsigned         DEBOUNCE_CYCLES = 4,
  parameter int unsigned         MODE            = 0,
  parameter logic [CHANNELS-1:0] INIT            = '0
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic                En,
  input  logic [CHANNELS-1:0] S,
  input  logic [CHANNELS-1:0] R,
  input  logic                Clr_conflict,
  output logic [CHANNELS-1:0] Q,
  output logic [CHANNELS-1:0] Changed,
  output logic [CHANNELS-1:0] Conflict
);

  // S and R are handled as one vector: bits [CHANNELS-1:0] = S, upper half = R
  localparam int unsigned NIN = 2 * CHANNELS;

  logic [NIN-1:0]                  raw;
  logic [SYNC_STAGES-1:0][NIN-1:0] sync_q;
  logic [NIN-1:0]                  sync;
  logic [NIN-1:0]                  filt;
  logic [CHANNELS-1:0]             fs;
  logic [CHANNELS-1:0]             fr;
  logic [CHANNELS-1:0]             both;
  logic [CHANNELS-1:0]             both_q;
  logic [CHANNELS-1:0]             q_q, q_d;
  logic [CHANNELS-1:0]             changed_q, changed_d;
  logic [CHANNELS-1:0]             conflict_q, conflict_d;

  assign raw  = {R, S};
  assign sync = sync_q[SYNC_STAGES-1];

  // Synchroniser shift chain for every raw input
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
    end
  end

  if (DEBOUNCE_CYCLES == 0) begin : g_bypass
    assign filt = sync;
  end else begin : g_deb
    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [NIN-1:0][CW-1:0] cnt_q, cnt_d;
    logic [NIN-1:0]         filt_q, filt_d;

    // Per-input stability counter; filtered value flips after DEBOUNCE_CYCLES differing cycles
    always_comb begin
      cnt_d  = cnt_q;
      filt_d = filt_q;
      for (int k = 0; k < int'(NIN); k++) begin
        if (sync[k] == filt_q[k]) begin
          cnt_d[k] = '0;
        end else if (cnt_q[k] == CW'(DEBOUNCE_CYCLES - 1)) begin
          filt_d[k] = sync[k];
          cnt_d[k]  = '0;
        end else begin
          cnt_d[k] = cnt_q[k] + CW'(1);
        end
      end
    end

    // Debounce state registers
    always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
        cnt_q  <= '0;
        filt_q <= '0;
      end else begin
        cnt_q  <= cnt_d;
        filt_q <= filt_d;
      end
    end

    assign filt = filt_q;
  end

  assign fs   = filt[CHANNELS-1:0];
  assign fr   = filt[NIN-1:CHANNELS];
  assign both = fs & fr;

  // Next Q, change pulse and sticky conflict per channel
  always_comb begin
    q_d        = q_q;
    conflict_d = conflict_q & ~{CHANNELS{Clr_conflict}};
    if (En) begin
      for (int i = 0; i < int'(CHANNELS); i++) begin
        case ({fs[i], fr[i]})
          2'b10: q_d[i] = 1'b1;
          2'b01: q_d[i] = 1'b0;
          2'b11: begin
            if (MODE == 2) begin
              // toggle only on the rising edge of the S&R condition
              if (!both_q[i]) q_d[i] = ~q_q[i];
            end else begin
              q_d[i]        = (MODE == 1);
              conflict_d[i] = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
    changed_d = q_d ^ q_q;
  end

  // Output and edge-history registers; edge history tracks regardless of En
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      q_q        <= INIT;
      changed_q  <= '0;
      conflict_q <= '0;
      both_q     <= '0;
    end else begin
      q_q        <= q_d;
      changed_q  <= changed_d;
      conflict_q <= conflict_d;
      both_q     <= both;
    end
  end

  assign Q        = q_q;
  assign Changed  = changed_q;
  assign Conflict = conflict_q;

endmodule
